alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 132 +++++++++++++
 tb/tb_alu_multicycle.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, and bit-serial shifts
// that take one cycle per shift position. Valid/ready handshake on both sides.
module alu_multicycle #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  BrTaken
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_BGE = 4'b1010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic                    br_q, br_d;

  logic [DATA_WIDTH-1:0]   alu_res;
  logic                    alu_br;
  logic                    is_shift;

  assign is_shift = (Operation == OP_SLL) || (Operation == OP_SRL) || (Operation == OP_SRA);

  // Single-cycle result for the operation on the inputs. Shift codes yield SrcA
  // unchanged: that is both the shamt=0 result and the working-register seed.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (Operation)
      OP_AND: alu_res = SrcA & SrcB;
      OP_OR:  alu_res = SrcA | SrcB;
      OP_ADD: alu_res = SrcA + SrcB;
      OP_XOR: alu_res = SrcA ^ SrcB;
      OP_SUB: alu_res = SrcA - SrcB;
      OP_SLT: alu_br  = $signed(SrcA) < $signed(SrcB);
      OP_BEQ: alu_br  = (SrcA == SrcB);
      OP_BGE: alu_br  = $signed(SrcA) >= $signed(SrcB);
      OP_SLL, OP_SRL, OP_SRA: alu_res = SrcA;
      default: alu_res = '0;
    endcase
    if ((Operation == OP_SLT) || (Operation == OP_BEQ) || (Operation == OP_BGE)) begin
      alu_res = {{(DATA_WIDTH-1){1'b0}}, alu_br};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    br_d    = br_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d  = Operation;
          cnt_d = SrcB[4:0];
          res_d = alu_res;
          br_d  = alu_br;
          state_d = (is_shift && (SrcB[4:0] != 5'd0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        case (op_q)
          OP_SLL:  res_d = {res_q[DATA_WIDTH-2:0], 1'b0};
          OP_SRL:  res_d = {1'b0, res_q[DATA_WIDTH-1:1]};
          default: res_d = {res_q[DATA_WIDTH-1], res_q[DATA_WIDTH-1:1]};
        endcase
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      br_q    <= br_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ALUResult = res_q;
  assign BrTaken   = br_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: a latency/result model checked every cycle,
// plus hand-computed expectations for each directed operation.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  Operation = '0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] ALUResult;
  logic        BrTaken;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .BrTaken   (BrTaken)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result from plain operators, latency = shamt+1 for shifts.
  typedef struct {
    logic [31:0] res;
    logic        br;
    int          lat;
  } exp_t;

  function automatic exp_t model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sh;
    sh    = int'(b[4:0]);
    e.res = '0;
    e.br  = 1'b0;
    e.lat = 1;
    case (op)
      4'd0:  e.res = a & b;
      4'd1:  e.res = a | b;
      4'd2:  e.res = a + b;
      4'd3:  e.res = a ^ b;
      4'd4:  e.res = a - b;
      4'd5:  begin e.br = ($signed(a) < $signed(b));  e.res = {31'd0, e.br}; end
      4'd6:  begin e.res = a << sh; e.lat = sh + 1; end
      4'd7:  begin e.res = a >> sh; e.lat = sh + 1; end
      4'd8:  begin e.br = (a == b); e.res = {31'd0, e.br}; end
      4'd9:  begin e.res = $signed(a) >>> sh; e.lat = sh + 1; end
      4'd10: begin e.br = ($signed(a) >= $signed(b)); e.res = {31'd0, e.br}; end
      default: e.res = '0;
    endcase
    return e;
  endfunction

  exp_t acc_exp;
  always_comb acc_exp = model_alu(Operation, SrcA, SrcB);

  // m_busy: an operation is in flight; m_left: edges remaining until its result shows.
  logic m_busy = 1'b0;
  int   m_left = 0;
  exp_t m_exp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_left <= 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_exp  <= acc_exp;
        m_left <= acc_exp.lat - 1;
        m_busy <= 1'b1;
      end
    end else if (m_left == 0) begin
      if (out_ready) m_busy <= 1'b0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready", 64'(in_ready), 64'(!m_busy));
    check("cyc_out_valid", 64'(out_valid), 64'(m_busy && (m_left == 0)));
    if (m_busy && (m_left == 0)) begin
      check("cyc_result", 64'(ALUResult), 64'(m_exp.res));
      check("cyc_brtaken", 64'(BrTaken), 64'(m_exp.br));
    end
  end

  // Issue one operation, verify latency and hand-computed result, and optionally
  // stall the consumer for `hold` cycles while junk appears on the inputs.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic eb,
                       input int el, input int hold);
    int lat;
    @(negedge clk);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    check({name, "_model_res"}, 64'(m_exp.res), 64'(er));
    in_valid  = 1'b0;
    Operation = 4'($urandom);
    SrcA      = $urandom;
    SrcB      = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    check({name, "_latency"}, 64'(lat), 64'(el));
    check({name, "_result"}, 64'(ALUResult), 64'(er));
    check({name, "_brtaken"}, 64'(BrTaken), 64'(eb));
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      Operation = 4'($urandom);
      SrcA      = $urandom;
      SrcB      = $urandom;
      @(negedge clk);
      check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({name, "_hold_result"}, 64'(ALUResult), 64'(er));
      check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_back_idle"}, 64'(in_ready), 64'd1);
    check({name, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 64'(ALUResult), 64'd0);
    check("rst_brtaken", 64'(BrTaken), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    do_op("add",     4'd2,  32'd7,          32'd5,          32'd12,         1'b0, 1,  0);
    do_op("sub",     4'd4,  32'd0,          32'd1,          32'hFFFFFFFF,   1'b0, 1,  0);
    do_op("bge_neg", 4'd10, 32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1,  0);
    do_op("bge_eq",  4'd10, 32'd9,          32'd9,          32'd1,          1'b1, 1,  0);
    do_op("beq",     4'd8,  32'h1234,       32'h1234,       32'd1,          1'b1, 1,  0);
    do_op("beq_ne",  4'd8,  32'h1234,       32'h1235,       32'd0,          1'b0, 1,  0);
    do_op("slt",     4'd5,  32'hFFFFFFFF,   32'd1,          32'd1,          1'b1, 1,  0);
    do_op("and",     4'd0,  32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  1'b0, 1,  0);
    do_op("or",      4'd1,  32'hF000_0001,  32'h0000_0F00,  32'hF000_0F01,  1'b0, 1,  0);
    do_op("add_wrap",4'd2,  32'hFFFFFFFF,   32'd2,          32'd1,          1'b0, 1,  0);
    do_op("undef",   4'd12, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd0,          1'b0, 1,  0);
    do_op("sra",     4'd9,  32'h80000000,   32'd4,          32'hF8000000,   1'b0, 5,  0);
    do_op("srl",     4'd7,  32'h80000000,   32'd4,          32'h08000000,   1'b0, 5,  0);
    do_op("sll31",   4'd6,  32'd1,          32'd31,         32'h80000000,   1'b0, 32, 0);
    do_op("sll0",    4'd6,  32'hDEADBEEF,   32'h20,         32'hDEADBEEF,   1'b0, 1,  0);
    do_op("xor_hold",4'd3,  32'hA5A5A5A5,   32'hFFFF0000,   32'h5A5AA5A5,   1'b0, 1,  3);

    // Reset pulse in the middle of a 20-position logical right shift.
    @(negedge clk);
    Operation = 4'd7;
    SrcA      = 32'hFFFF0000;
    SrcB      = 32'd20;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_result", 64'(ALUResult), 64'd0);
    check("midrst_brtaken", 64'(BrTaken), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    do_op("add_after_rst", 4'd2, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
